// File: rtl/tex_pkg.sv
// Shared texture-load definitions: asset encoding, asset sizes/locations and
// loader FSM state encoding. The renderer imports the same sizes.
package tex_pkg;

    localparam int BIRD_WORDS = 5250;
    localparam int PIPE_WORDS = 40000;
    localparam int BASE_WORDS = 9600;

    localparam logic [23:0] BIRD_SRC = 24'h100000;
    localparam logic [23:0] PIPE_SRC = 24'h102000;
    localparam logic [23:0] BASE_SRC = 24'h10C000;

    localparam int DEF_TIMEOUT_CYC = 1000000;

    typedef enum logic [1:0] {
        ASSET_BIRD = 2'd0,
        ASSET_PIPE = 2'd1,
        ASSET_BASE = 2'd2
    } asset_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_STREAM = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    function automatic logic [15:0] asset_len(input asset_t a);
        case (a)
            ASSET_BIRD: return 16'(BIRD_WORDS);
            ASSET_PIPE: return 16'(PIPE_WORDS);
            default:    return 16'(BASE_WORDS);
        endcase
    endfunction

    function automatic logic [23:0] asset_src(input asset_t a);
        case (a)
            ASSET_BIRD: return BIRD_SRC;
            ASSET_PIPE: return PIPE_SRC;
            default:    return BASE_SRC;
        endcase
    endfunction

endpackage

// File: rtl/tex_write_router.sv
// Registered demux of returned SDRAM words onto the three texture-RAM write
// ports; owns the single cycle of write latency.
module tex_write_router
    import tex_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        asset,
    input  logic [15:0]       word_cnt,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              vld_p0,
    output logic              bird_load_en,
    output logic [12:0]       bird_load_addr,
    output logic              pipe_load_en,
    output logic [15:0]       pipe_load_addr,
    output logic              base_load_en,
    output logic [13:0]       base_load_addr,
    output logic [DATA_W-1:0] load_data
);

    logic              bird_vld_p1;
    logic              pipe_vld_p1;
    logic              base_vld_p1;
    logic [15:0]       addr_p1;
    logic [DATA_W-1:0] data_p1;

    // p0 -> p1: select the port from the asset index and capture address/data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bird_vld_p1 <= 1'b0;
            pipe_vld_p1 <= 1'b0;
            base_vld_p1 <= 1'b0;
            addr_p1     <= '0;
            data_p1     <= '0;
        end else begin
            bird_vld_p1 <= vld_p0 && (asset == ASSET_BIRD);
            pipe_vld_p1 <= vld_p0 && (asset == ASSET_PIPE);
            base_vld_p1 <= vld_p0 && (asset == ASSET_BASE);
            if (vld_p0) begin
                addr_p1 <= word_cnt;
                data_p1 <= wr_data;
            end
        end
    end

    assign bird_load_en   = bird_vld_p1;
    assign pipe_load_en   = pipe_vld_p1;
    assign base_load_en   = base_vld_p1;
    assign bird_load_addr = addr_p1[12:0];
    assign pipe_load_addr = addr_p1;
    assign base_load_addr = addr_p1[13:0];
    assign load_data      = data_p1;

endmodule

// File: rtl/sprite_tex_loader.sv
// Boot-time texture sequencer: bursts bird, pipe and ground assets from SDRAM
// into the renderer's texture RAMs. Define SPRITE_TEX_LOADER_TIMEOUT_EN for the watchdog/ERR state.
module sprite_tex_loader
    import tex_pkg::*;
#(
    parameter int DATA_W = 16
`ifdef SPRITE_TEX_LOADER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_req,
    output logic [23:0]       rd_addr,
    output logic [15:0]       rd_len,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              bird_load_en,
    output logic [12:0]       bird_load_addr,
    output logic              pipe_load_en,
    output logic [15:0]       pipe_load_addr,
    output logic              base_load_en,
    output logic [13:0]       base_load_addr,
    output logic [DATA_W-1:0] load_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t      state;
    state_t      state_nxt;
    asset_t      asset;
    logic [15:0] word_cnt;
    logic [15:0] cur_len;
    logic [23:0] cur_src;
    logic        start_ok;
    logic        vld_p0;
    logic        last_word;

    assign cur_len   = asset_len(asset);
    assign cur_src   = asset_src(asset);
    // start is only honoured when no sequence is in flight
    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign vld_p0    = rd_valid && (state == ST_STREAM);
    assign last_word = vld_p0 && (word_cnt == cur_len - 16'd1);

`ifdef SPRITE_TEX_LOADER_TIMEOUT_EN
    logic [19:0] wd_cnt;
    logic        wd_run;
    logic        wd_hit;

    assign wd_run = (state == ST_REQ && !rd_ack) || (state == ST_STREAM && !rd_valid);
    assign wd_hit = wd_run && (wd_cnt == 20'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         wd_cnt <= '0;
        else if (wd_run) wd_cnt <= wd_cnt + 20'd1;
        else             wd_cnt <= '0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start)  state_nxt = ST_REQ;
            ST_REQ:           if (rd_ack) state_nxt = ST_STREAM;
            ST_STREAM:        if (last_word) state_nxt = ST_NEXT;
            ST_NEXT:          state_nxt = (asset == ASSET_BASE) ? ST_DONE : ST_REQ;
`ifdef SPRITE_TEX_LOADER_TIMEOUT_EN
            ST_ERR:           if (start)  state_nxt = ST_REQ;
`endif
            default:          state_nxt = ST_IDLE;
        endcase
`ifdef SPRITE_TEX_LOADER_TIMEOUT_EN
        if (wd_hit) state_nxt = ST_ERR;
`endif
    end

    always_comb begin
        rd_req  = (state == ST_REQ);
        rd_addr = rd_req ? cur_src : 24'd0;
        rd_len  = rd_req ? cur_len : 16'd0;
        busy    = (state == ST_REQ) || (state == ST_STREAM) || (state == ST_NEXT);
        done    = (state == ST_DONE);
`ifdef SPRITE_TEX_LOADER_TIMEOUT_EN
        error   = (state == ST_ERR);
`else
        error   = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asset    <= ASSET_BIRD;
            word_cnt <= '0;
        end else begin
            if (start_ok)
                asset <= ASSET_BIRD;
            else if (state == ST_NEXT && asset != ASSET_BASE)
                asset <= asset_t'(asset + 2'd1);
            if (state == ST_REQ && rd_ack)
                word_cnt <= '0;
            else if (vld_p0)
                word_cnt <= word_cnt + 16'd1;
        end
    end

    tex_write_router #(
        .DATA_W (DATA_W)
    ) u_router (
        .clk            (clk),
        .rst            (rst),
        .asset          (asset),
        .word_cnt       (word_cnt),
        .wr_data        (rd_data),
        .vld_p0         (vld_p0),
        .bird_load_en   (bird_load_en),
        .bird_load_addr (bird_load_addr),
        .pipe_load_en   (pipe_load_en),
        .pipe_load_addr (pipe_load_addr),
        .base_load_en   (base_load_en),
        .base_load_addr (base_load_addr),
        .load_data      (load_data)
    );

endmodule
